// File: rtl/system_lm96570_spi_out_capture_if.sv
// Avalon-MM slave bus bundle for the LM96570 SDO capture block.
// Bus semantics: there is no waitrequest. A write is the single cycle
// where chipselect=1 and write_n=0, and it is applied on the next rising clk.
// A read is zero-wait: readdata is a combinational function of address and
// register state, and reading never changes state.
interface system_lm96570_spi_out_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/system_lm96570_spi_out_capture.sv
// LM96570 SDO readback capture. The CPU bit-bangs SCLK/SLE/SDI, and this block
// deserialises SDO inside each SLE-low frame. Each completed frame is latched
// into DATA with a done flag, a bit count, an overflow flag and an irq.
module system_lm96570_spi_out_capture #(
  parameter int DATA_W      = 32,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  system_lm96570_spi_out_capture_if.slave       bus,
  input  logic                                  spi_sclk,
  input  logic                                  spi_sle,
  input  logic                                  spi_sdo,
  output logic                                  irq,
  output logic [1:0]                            fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sle_s1, sle_s2, sle_s3;
  logic sdo_s1, sdo_s2;

  logic [DATA_W-1:0] shift_q;
  logic [5:0]        count_q;
  logic              frame_ovf_q;
  logic [DATA_W-1:0] data_q;
  logic [5:0]        last_count_q;
  logic              done_q;
  logic              ovf_q;
  logic              ctrl_enable_q;
  logic              ctrl_rise_q;
  logic              ctrl_irq_en_q;

  logic start_frame, shift_en, commit;

  // SDO uses the same synchroniser depth as SCLK, so a bit is sampled with
  // the same timing relationship it had at the pins.
  logic sclk_rise, sclk_fall, sle_rise, sle_fall, sample_edge;
  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign sle_rise    = sle_s2 & ~sle_s3;
  assign sle_fall    = ~sle_s2 & sle_s3;
  assign sample_edge = ctrl_rise_q ? sclk_rise : sclk_fall;

  logic wr, wr_ctrl, wr_clear, disable_req;
  assign wr          = bus.chipselect & ~bus.write_n;
  assign wr_ctrl     = wr & (bus.address == 2'd2);
  assign wr_clear    = wr & (bus.address == 2'd3) & bus.writedata[0];
  assign disable_req = wr_ctrl & ~bus.writedata[0];

  logic unused_writedata;
  assign unused_writedata = &{1'b0, bus.writedata[31:3]};

  // Pin synchronisers: two FFs per pin, plus a third for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
      sle_s1  <= 1'b0; sle_s2  <= 1'b0; sle_s3  <= 1'b0;
      sdo_s1  <= 1'b0; sdo_s2  <= 1'b0;
    end else begin
      sclk_s1 <= spi_sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      sle_s1  <= spi_sle;  sle_s2  <= sle_s1;  sle_s3  <= sle_s2;
      sdo_s1  <= spi_sdo;  sdo_s2  <= sdo_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state. SLE rising has priority over an SCLK edge in the same cycle.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    if (disable_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_enable_q) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (!ctrl_enable_q) begin
            state_d = ST_IDLE;
          end else if (sle_fall) begin
            state_d     = ST_SHIFT;
            start_frame = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!ctrl_enable_q) begin
            state_d = ST_IDLE;
          end else if (sle_rise) begin
            state_d = ST_WAIT;
            commit  = (count_q != 6'd0);
          end else if (sample_edge) begin
            shift_en = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame shift register, saturating bit counter and per-frame overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      count_q     <= 6'd0;
      frame_ovf_q <= 1'b0;
    end else if (start_frame) begin
      shift_q     <= '0;
      count_q     <= 6'd0;
      frame_ovf_q <= 1'b0;
    end else if (shift_en) begin
      shift_q <= (shift_q << 1) | DATA_W'(sdo_s2);
      if (count_q != 6'd63) count_q <= count_q + 6'd1;
      if (32'(count_q) >= 32'(DATA_W)) frame_ovf_q <= 1'b1;
    end
  end

  // CPU-visible registers. A frame commit wins over CLEAR in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= '0;
      last_count_q  <= 6'd0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      ctrl_enable_q <= 1'b0;
      ctrl_rise_q   <= SAMPLE_RISE;
      ctrl_irq_en_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable_q <= bus.writedata[0];
        ctrl_rise_q   <= bus.writedata[1];
        ctrl_irq_en_q <= bus.writedata[2];
      end
      if (wr_clear) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (commit) begin
        data_q       <= shift_q;
        last_count_q <= count_q;
        done_q       <= 1'b1;
        ovf_q        <= frame_ovf_q;
      end
    end
  end

  // Zero-wait read mux.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(data_q);
      2'd1:    bus.readdata = {18'd0, last_count_q, 6'd0, ovf_q, done_q};
      2'd2:    bus.readdata = {29'd0, ctrl_irq_en_q, ctrl_rise_q, ctrl_enable_q};
      default: bus.readdata = 32'd0;
    endcase
  end

  assign irq       = done_q & ctrl_irq_en_q;
  assign fsm_state = state_q;

endmodule
